// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a busywait instruction memory,
// buffers up to two fetched instructions and handles EX redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic        IF_VALID
);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [1:0]  count;
    logic [31:0] head_pc, head_instr;
    logic [31:0] tail_pc, tail_instr;

    logic        rd;
    logic        valid;
    logic        rsp;
    logic        pop;
    logic        fifo_en;
    logic [31:0] target;

    assign target    = BRANCH_TARGET & ~32'h3;
    assign rd        = !RESET && (state == DISCARD || count != 2'd2);
    assign valid     = !RESET && (count != 2'd0) && (state == FETCH);
    assign rsp       = rd && !IMEM_BUSYWAIT;
    assign pop       = valid && !STALL;
    assign fifo_en   = !RESET && !BRANCH_TAKEN && (state == FETCH);

    assign IMEM_ADDR      = pc;
    assign IMEM_READ      = rd;
    assign IF_VALID       = valid;
    assign IF_PC          = valid ? head_pc    : 32'h0;
    assign IF_INSTRUCTION = valid ? head_instr : NOP_INSTR;

    // Control: PC, occupancy, redirect bookkeeping and FSM
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc       <= RESET_PC;
            count    <= 2'd0;
            state    <= FETCH;
            redir_pc <= 32'h0;
        end else if (BRANCH_TAKEN) begin
            count <= 2'd0;
            if (state == FETCH) begin
                // An in-flight read cannot be aborted; park the target until it completes
                if (rd && IMEM_BUSYWAIT) begin
                    redir_pc <= target;
                    state    <= DISCARD;
                end else begin
                    pc <= target;
                end
            end else begin
                redir_pc <= target;
                if (!IMEM_BUSYWAIT) begin
                    pc    <= target;
                    state <= FETCH;
                end
            end
        end else if (state == DISCARD) begin
            if (!IMEM_BUSYWAIT) begin
                pc    <= redir_pc;
                state <= FETCH;
            end
        end else begin
            if (rsp)
                pc <= pc + 32'd4;
            count <= count + {1'b0, rsp} - {1'b0, pop};
        end
    end

    // Two-entry FIFO storage; a simultaneous push/pop at one entry lands in the head
    always_ff @(posedge CLK) begin
        if (fifo_en) begin
            if (rsp && (count == 2'd0 || (count == 2'd1 && pop))) begin
                head_pc    <= pc;
                head_instr <= IMEM_READDATA;
            end else if (pop) begin
                head_pc    <= tail_pc;
                head_instr <= tail_instr;
            end
            if (rsp && count == 2'd1 && !pop) begin
                tail_pc    <= pc;
                tail_instr <= IMEM_READDATA;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based fetch model and a
// busywait memory whose per-access latency is drawn at random.
module tb_if_fetch_unit;

    localparam logic [31:0] RP  = 32'hFFFFFFF8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic [31:0] IMEM_READDATA = 32'h0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTRUCTION;
    logic        IF_VALID;

    if_fetch_unit #(.RESET_PC(RP), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_READ(IMEM_READ),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IF_PC(IF_PC), .IF_INSTRUCTION(IF_INSTRUCTION), .IF_VALID(IF_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: buffered instructions, fetch address, redirect pending
    ent_t        q[$];
    logic [31:0] m_pc = RP;
    logic        m_disc = 1'b0;
    logic [31:0] m_redir = 32'h0;

    // Memory model: busy cycles left for the current access
    int bw_left = 0;
    int wmin = 0;
    int wmax = 0;

    int vectors = 0;
    int miscompares = 0;

    function automatic int pick();
        return $urandom_range(wmax, wmin);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic rst);
        logic er, ev;
        er = !rst && (m_disc || q.size() < 2);
        ev = !rst && q.size() > 0 && !m_disc;
        check("IMEM_READ", {31'h0, IMEM_READ}, {31'h0, er});
        check("IF_VALID", {31'h0, IF_VALID}, {31'h0, ev});
        check("IF_PC", IF_PC, ev ? q[0].pc : 32'h0);
        check("IF_INSTRUCTION", IF_INSTRUCTION, ev ? q[0].ins : NOP);
        check("IMEM_ADDR", IMEM_ADDR, m_pc);
    endtask

    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
        logic er, ev, bw;
        logic [31:0] t;
        ent_t e;
        er = !rst && (m_disc || q.size() < 2);
        ev = !rst && q.size() > 0 && !m_disc;
        bw = er && (bw_left > 0);
        RESET = rst; STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        IMEM_BUSYWAIT = bw;
        IMEM_READDATA = m_pc ^ 32'hA5A5A5A5;
        @(posedge CLK);
        #1;
        if (rst) bw_left = pick();
        else if (er) begin
            if (bw_left > 0) bw_left--;
            else bw_left = pick();
        end
        t = {tgt[31:2], 2'b00};
        if (rst) begin
            m_pc = RP; q.delete(); m_disc = 1'b0; m_redir = 32'h0;
        end else if (br) begin
            q.delete();
            if (!m_disc) begin
                if (er && bw) begin m_redir = t; m_disc = 1'b1; end
                else m_pc = t;
            end else begin
                m_redir = t;
                if (!bw) begin m_pc = t; m_disc = 1'b0; end
            end
        end else if (m_disc) begin
            if (!bw) begin m_pc = m_redir; m_disc = 1'b0; end
        end else begin
            if (ev && !st) void'(q.pop_front());
            if (er && !bw) begin
                e.pc = m_pc; e.ins = m_pc ^ 32'hA5A5A5A5;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        check_outputs(rst);
    endtask

    // Step until the memory is mid-access on a fetch, then redirect
    task automatic branch_while_busy(input logic [31:0] tgt);
        int n = 0;
        while (!(!m_disc && q.size() < 2 && bw_left > 0) && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $error("FAIL busy_wait_bound observed=%0d expected=<20", n);
        end
        step(0, 0, 1, tgt);
    endtask

    initial begin
        int n;
        // Zero-wait streaming from reset, including PC wrap
        wmin = 0; wmax = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // Three busy cycles per access
        wmin = 3; wmax = 3;
        step(1, 0, 0, 0);
        repeat (16) step(0, 0, 0, 0);

        // Stall holds the head while the FIFO fills, then drains back-to-back
        wmin = 0; wmax = 0;
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);

        // Redirect during a busy read goes through DISCARD
        wmin = 2; wmax = 2;
        branch_while_busy(32'h100);
        repeat (8) step(0, 0, 0, 0);

        // Redirect with a full FIFO and no read in flight; unaligned target
        wmin = 0; wmax = 0;
        n = 0;
        while (q.size() < 2 && n < 10) begin step(0, 1, 0, 0); n++; end
        step(0, 1, 1, 32'h203);
        repeat (4) step(0, 0, 0, 0);

        // Second redirect inside DISCARD, then reset during DISCARD
        wmin = 3; wmax = 3;
        branch_while_busy(32'h400);
        step(0, 0, 1, 32'h800);
        repeat (6) step(0, 0, 0, 0);
        branch_while_busy(32'h500);
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);

        // Randomized traffic
        wmin = 0; wmax = 3;
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(99, 0);
            step(r == 0, ($urandom_range(9, 0) < 3), (r >= 1 && r <= 6), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the IF_PC / IF_INSTRUCTION pair consumed by the IF/ID pipeline register. It owns the PC and drives a busywait-style instruction-memory read interface. It buffers up to two fetched instructions so hazard stalls never abort a memory read. It also handles branch/jump redirects from EX, including redirects that arrive while a read is still in flight.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction presented when no valid fetch is available (addi x0,x0,0).

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET  input  1  reset, synchronous, active-high.
STALL  input  1  pipeline cannot accept a new instruction this cycle.
BRANCH_TAKEN  input  1  redirect request from EX stage.
BRANCH_TARGET  input  32  redirect byte address.
IMEM_ADDR  output  32  instruction-memory byte address.
IMEM_READ  output  1  read request.
IMEM_READDATA  input  32  read data; valid in any cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
IMEM_BUSYWAIT  input  1  memory not ready.
IF_PC  output  32  PC of the presented instruction.
IF_INSTRUCTION  output  32  presented instruction.
IF_VALID  output  1  IF_PC / IF_INSTRUCTION hold a real fetched instruction.

Behaviour:
- State: PC register, 2-entry FIFO of {pc, instr}, COUNT (0..2), REDIR_PC, FSM {FETCH, DISCARD}.
- Reset: PC=RESET_PC, COUNT=0, FSM=FETCH, REDIR_PC=0.
- While RESET=1: IMEM_READ=0, IF_VALID=0, IF_PC=0, IF_INSTRUCTION=NOP_INSTR.
- Priority at each posedge: RESET > BRANCH_TAKEN > normal operation.
- IMEM_ADDR = PC at all times (combinational from the PC register).
- FETCH:
  - IMEM_READ = (COUNT<2).
  - Response = IMEM_READ & !IMEM_BUSYWAIT. On a response, push {PC, IMEM_READDATA} and set PC <= PC+4 (32-bit, wraps modulo 2^32).
- Pop = IF_VALID & !STALL.
  - Push and pop in the same cycle: COUNT unchanged, order preserved.
  - Pop at COUNT=2 with no push: COUNT=1; IMEM_READ reasserts the next cycle.
  - A read is only started when COUNT<2. Once started, IMEM_READ stays high until the response arrives; a read is never aborted by STALL.
- Outputs:
  - IF_VALID = (COUNT>0) & FSM==FETCH.
  - When IF_VALID=1: IF_PC / IF_INSTRUCTION = FIFO head.
  - When IF_VALID=0: IF_PC=0, IF_INSTRUCTION=NOP_INSTR.
  - All outputs are combinational from registers only; no combinational path from STALL or IMEM_* to IF_*.
- Latency: with a zero-wait memory, the instruction at PC p is presented the cycle after the cycle in which IMEM_ADDR=p. Steady-state throughput is 1 instruction/cycle.
- BRANCH_TAKEN=1 in FETCH:
  - FIFO is flushed (COUNT=0) and the response of that cycle, if any, is dropped.
  - Target is {BRANCH_TARGET[31:2],2'b00}; low two bits are forced to 0.
  - If IMEM_READ & IMEM_BUSYWAIT (read in flight): REDIR_PC <= target, FSM -> DISCARD, PC unchanged.
  - Else: PC <= target, FSM stays FETCH.
- DISCARD:
  - IMEM_READ=1 with IMEM_ADDR = old PC (completes the in-flight read); IF_VALID=0; COUNT stays 0.
  - On IMEM_BUSYWAIT=0: data dropped, PC <= REDIR_PC, FSM -> FETCH.
  - BRANCH_TAKEN during DISCARD: REDIR_PC overwritten with the new target. If that cycle is also the completion cycle, PC <= new target.
- STALL is ignored in DISCARD and in any cycle with BRANCH_TAKEN=1.
- Reset mid-operation (any state): the next cycle follows the reset state above. Instruction memory is reset by the same RESET, so the in-flight read is abandoned.

Test Plan:
1. Reset with zero-wait memory returning data=addr^32'hA5A5A5A5 -> IMEM_ADDR 0,4,8… on consecutive cycles; IF_VALID rises the cycle after reset release; IF_PC 0,4,8,C one per cycle with matching data.
2. Memory with 3 busywait cycles per access -> IF_VALID pulses once per 4 cycles; IF_PC sequence 0,4,8 with no duplicates or gaps.
3. Zero-wait memory, STALL held 4 cycles starting when IF_PC=8 -> COUNT reaches 2; IMEM_READ low while full; IF_PC held at 8; after release IF_PC 8,C,10 back-to-back with no skip.
4. BRANCH_TAKEN with target 0x100 while the read at 0x10 is busy (2 more busy cycles) -> FSM enters DISCARD; IMEM_ADDR stays 0x10 until busywait drops; data at 0x10 is never presented; the first valid IF_PC after the redirect is 0x100.
5. BRANCH_TAKEN with target 0x203, no read in flight, COUNT=2 -> IF_VALID=0 the next cycle, IMEM_ADDR=0x200, then IF_PC=0x200.
6. RESET_PC=32'hFFFFFFFC -> IF_PC FFFFFFFC then 00000000. RESET asserted during DISCARD -> IMEM_READ=0, IF_INSTRUCTION=NOP_INSTR, then fetch restarts at RESET_PC.
